// File: rtl/bus_pkg.sv
// Shared definitions for the two-master system bus arbiter: bus instruction
// codes, arbiter state encoding and owner identifiers.
package bus_pkg;

   localparam logic [1:0] INSTR_NONE  = 2'b00;
   localparam logic [1:0] INSTR_WRITE = 2'b10;
   localparam logic [1:0] INSTR_READ  = 2'b11;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      GRANT_M1 = 2'b01,
      GRANT_M2 = 2'b10,
      RELEASE  = 2'b11
   } arb_state_t;

   typedef enum logic {
      OWNER_M1 = 1'b0,
      OWNER_M2 = 1'b1
   } owner_t;

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts cycles while a master owns the bus and flags expiry
// on the cycle the count reaches LIMIT-1. Clearing outside a grant means every
// new owner starts from zero.
module arb_watchdog #(
   parameter int unsigned LIMIT = 1023
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] count;

   // Cycle counter, restarted whenever the bus is not owned.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expire = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter. The owner's request fields are captured
// on the grant edge and held until the bus reports trans_done, followed by one
// dead RELEASE cycle before the next owner.
// Optional feature macro: ARB_TIMEOUT_EN adds a grant watchdog that forces a
// release (without a done pulse) and sets a sticky timeout_err.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned SLAVE_LEN      = 2,
   parameter int unsigned ADDR_LEN       = 12,
   parameter int unsigned DATA_LEN       = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 m1_req,
   input  logic [1:0]           m1_instruction,
   input  logic [SLAVE_LEN-1:0] m1_slave_select,
   input  logic [ADDR_LEN-1:0]  m1_address,
   input  logic [DATA_LEN-1:0]  m1_data,
   input  logic                 m2_req,
   input  logic [1:0]           m2_instruction,
   input  logic [SLAVE_LEN-1:0] m2_slave_select,
   input  logic [ADDR_LEN-1:0]  m2_address,
   input  logic [DATA_LEN-1:0]  m2_data,
   input  logic                 trans_done,
   output logic                 m1_grant,
   output logic                 m2_grant,
   output logic                 m1_done,
   output logic                 m2_done,
   output logic [1:0]           instruction,
   output logic [SLAVE_LEN-1:0] slave_select,
   output logic [ADDR_LEN-1:0]  address,
   output logic [DATA_LEN-1:0]  data_out,
   output logic                 bus_busy,
   output logic                 timeout_err
);

   arb_state_t           state, state_next;
   owner_t               last_owner, last_owner_next;
   logic                 m1_grant_next, m2_grant_next;
   logic                 m1_done_next, m2_done_next;
   logic [1:0]           instruction_next;
   logic [SLAVE_LEN-1:0] slave_select_next;
   logic [ADDR_LEN-1:0]  address_next;
   logic [DATA_LEN-1:0]  data_out_next;
   logic                 timeout_err_next;
   logic                 pick_m1, pick_m2;
   logic                 expire;

   assign bus_busy = (state == GRANT_M1) || (state == GRANT_M2);

   // On contention the master that did not own the bus last wins.
   assign pick_m1 = m1_req && (!m2_req || (last_owner == OWNER_M2));
   assign pick_m2 = m2_req && !pick_m1;

`ifdef ARB_TIMEOUT_EN
   arb_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (!bus_busy),
      .enable (bus_busy),
      .expire (expire)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign expire = 1'b0;
`endif

   // Next-state and next-output logic; everything the bus sees is registered.
   always_comb begin
      state_next        = state;
      last_owner_next   = last_owner;
      m1_grant_next     = m1_grant;
      m2_grant_next     = m2_grant;
      m1_done_next      = 1'b0;
      m2_done_next      = 1'b0;
      instruction_next  = instruction;
      slave_select_next = slave_select;
      address_next      = address;
      data_out_next     = data_out;
      timeout_err_next  = timeout_err;
      unique case (state)
         IDLE: begin
            if (pick_m1) begin
               state_next        = GRANT_M1;
               m1_grant_next     = 1'b1;
               instruction_next  = m1_instruction;
               slave_select_next = m1_slave_select;
               address_next      = m1_address;
               data_out_next     = m1_data;
            end else if (pick_m2) begin
               state_next        = GRANT_M2;
               m2_grant_next     = 1'b1;
               instruction_next  = m2_instruction;
               slave_select_next = m2_slave_select;
               address_next      = m2_address;
               data_out_next     = m2_data;
            end
         end
         GRANT_M1: begin
            if (trans_done || expire) begin
               state_next       = RELEASE;
               m1_grant_next    = 1'b0;
               instruction_next = INSTR_NONE;
               last_owner_next  = OWNER_M1;
               m1_done_next     = trans_done;
               timeout_err_next = timeout_err || !trans_done;
            end
         end
         GRANT_M2: begin
            if (trans_done || expire) begin
               state_next       = RELEASE;
               m2_grant_next    = 1'b0;
               instruction_next = INSTR_NONE;
               last_owner_next  = OWNER_M2;
               m2_done_next     = trans_done;
               timeout_err_next = timeout_err || !trans_done;
            end
         end
         RELEASE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         last_owner   <= OWNER_M2;
         m1_grant     <= 1'b0;
         m2_grant     <= 1'b0;
         m1_done      <= 1'b0;
         m2_done      <= 1'b0;
         instruction  <= INSTR_NONE;
         slave_select <= SLAVE_LEN'(1);
         address      <= '0;
         data_out     <= '0;
         timeout_err  <= 1'b0;
      end else begin
         state        <= state_next;
         last_owner   <= last_owner_next;
         m1_grant     <= m1_grant_next;
         m2_grant     <= m2_grant_next;
         m1_done      <= m1_done_next;
         m2_done      <= m2_done_next;
         instruction  <= instruction_next;
         slave_select <= slave_select_next;
         address      <= address_next;
         data_out     <= data_out_next;
         timeout_err  <= timeout_err_next;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter. Expected bus transactions are queued
// in grant order when requests are raised and checked as grants appear.
// Build with ARB_TIMEOUT_EN to exercise the watchdog (limit set to 8 here).
module tb_bus_arbiter;
   import bus_pkg::*;

   localparam int SLAVE_LEN      = 2;
   localparam int ADDR_LEN       = 12;
   localparam int DATA_LEN       = 8;
   localparam int TIMEOUT_CYCLES = 8;

   typedef struct {
      int                   owner;
      logic [1:0]           instr;
      logic [SLAVE_LEN-1:0] sel;
      logic [ADDR_LEN-1:0]  addr;
      logic [DATA_LEN-1:0]  data;
   } txn_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 m1_req, m2_req, trans_done;
   logic [1:0]           m1_instruction, m2_instruction;
   logic [SLAVE_LEN-1:0] m1_slave_select, m2_slave_select;
   logic [ADDR_LEN-1:0]  m1_address, m2_address;
   logic [DATA_LEN-1:0]  m1_data, m2_data;
   logic                 m1_grant, m2_grant, m1_done, m2_done;
   logic [1:0]           instruction;
   logic [SLAVE_LEN-1:0] slave_select;
   logic [ADDR_LEN-1:0]  address;
   logic [DATA_LEN-1:0]  data_out;
   logic                 bus_busy, timeout_err;

   txn_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   bus_arbiter #(
      .SLAVE_LEN      (SLAVE_LEN),
      .ADDR_LEN       (ADDR_LEN),
      .DATA_LEN       (DATA_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .m1_req          (m1_req),
      .m1_instruction  (m1_instruction),
      .m1_slave_select (m1_slave_select),
      .m1_address      (m1_address),
      .m1_data         (m1_data),
      .m2_req          (m2_req),
      .m2_instruction  (m2_instruction),
      .m2_slave_select (m2_slave_select),
      .m2_address      (m2_address),
      .m2_data         (m2_data),
      .trans_done      (trans_done),
      .m1_grant        (m1_grant),
      .m2_grant        (m2_grant),
      .m1_done         (m1_done),
      .m2_done         (m2_done),
      .instruction     (instruction),
      .slave_select    (slave_select),
      .address         (address),
      .data_out        (data_out),
      .bus_busy        (bus_busy),
      .timeout_err     (timeout_err)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m1_req = 1'b0; m2_req = 1'b0; trans_done = 1'b0;
      m1_instruction = 2'b00; m1_slave_select = '0; m1_address = '0; m1_data = '0;
      m2_instruction = 2'b00; m2_slave_select = '0; m2_address = '0; m2_data = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Raise a request and record the bus transaction it should produce.
   task automatic issue(input int master, input logic [1:0] instr, input logic [SLAVE_LEN-1:0] sel,
                        input logic [ADDR_LEN-1:0] addr, input logic [DATA_LEN-1:0] data);
      txn_t t;
      t.owner = master; t.instr = instr; t.sel = sel; t.addr = addr; t.data = data;
      sb.push_back(t);
      if (master == 1) begin
         m1_req = 1'b1; m1_instruction = instr; m1_slave_select = sel; m1_address = addr; m1_data = data;
      end else begin
         m2_req = 1'b1; m2_instruction = instr; m2_slave_select = sel; m2_address = addr; m2_data = data;
      end
   endtask

   // Wait (bounded) for a grant and check it against the oldest expected transaction.
   task automatic wait_grant(output int cycles);
      txn_t exp;
      cycles = 0;
      while (!(m1_grant || m2_grant) && cycles < 20) begin
         step();
         cycles++;
      end
      vectors++;
      if (!(m1_grant || m2_grant)) begin
         miscompares++;
         $display("[TB] FAIL grant_wait: grants=%b after %0d cycles, required a grant", {m1_grant, m2_grant}, cycles);
         return;
      end
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL grant_unexpected: grants=%b, required no grant", {m1_grant, m2_grant});
         return;
      end
      exp = sb.pop_front();
      vectors++;
      if ({m1_grant, m2_grant} !== ((exp.owner == 1) ? 2'b10 : 2'b01)) begin
         miscompares++;
         $display("[TB] FAIL grant_owner: grants=%b, required owner M%0d", {m1_grant, m2_grant}, exp.owner);
      end
      vectors++;
      if ({instruction, slave_select, address, data_out, bus_busy} !== {exp.instr, exp.sel, exp.addr, exp.data, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL bus_fields: got %b/%0d/%0h/%0d busy=%b, required %b/%0d/%0h/%0d busy=1",
                  instruction, slave_select, address, data_out, bus_busy, exp.instr, exp.sel, exp.addr, exp.data);
      end
   endtask

   // Pulse trans_done in the current grant cycle and check the release sequence.
   task automatic finish_txn(input int master);
      logic [1:0] exp_done;
      exp_done = (master == 1) ? 2'b10 : 2'b01;
      trans_done = 1'b1;
      step();
      trans_done = 1'b0;
      vectors++;
      if ({m1_grant, m2_grant, m1_done, m2_done, instruction, bus_busy} !== {2'b00, exp_done, INSTR_NONE, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL release: grant=%b done=%b instr=%b busy=%b, required grant=00 done=%b instr=00 busy=0",
                  {m1_grant, m2_grant}, {m1_done, m2_done}, instruction, bus_busy, exp_done);
      end
      step();
      vectors++;
      if ({m1_grant, m2_grant, m1_done, m2_done, bus_busy} !== 5'b00000) begin
         miscompares++;
         $display("[TB] FAIL dead_cycle: grant=%b done=%b busy=%b, required all 0",
                  {m1_grant, m2_grant}, {m1_done, m2_done}, bus_busy);
      end
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({m1_grant, m2_grant, m1_done, m2_done, instruction, slave_select, address, data_out, bus_busy, timeout_err}
          !== {4'b0000, INSTR_NONE, 2'd1, 12'd0, 8'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL reset_values: grant=%b done=%b instr=%b sel=%0d addr=%0h data=%0d busy=%b err=%b, required sel=1 rest 0",
                  {m1_grant, m2_grant}, {m1_done, m2_done}, instruction, slave_select, address, data_out, bus_busy, timeout_err);
      end
   endtask

   task automatic test_single_write();
      int c;
      issue(1, INSTR_WRITE, 2'd1, 12'd1, 8'd77);
      wait_grant(c);
      vectors++;
      if (c !== 1) begin
         miscompares++;
         $display("[TB] FAIL grant_latency: %0d cycles, required 1", c);
      end
      step();
      step();
      finish_txn(1);
      m1_req = 1'b0;
      step();
      vectors++;
      if ({m1_grant, m2_grant, instruction} !== {2'b00, INSTR_NONE}) begin
         miscompares++;
         $display("[TB] FAIL idle_after_done: grant=%b instr=%b, required 00/00", {m1_grant, m2_grant}, instruction);
      end
   endtask

   task automatic test_round_robin();
      int c;
      txn_t t;
      do_reset();
      issue(1, INSTR_WRITE, 2'd1, 12'h010, 8'h11);
      issue(2, INSTR_READ,  2'd2, 12'h020, 8'h22);
      t.owner = 1; t.instr = INSTR_WRITE; t.sel = 2'd1; t.addr = 12'h010; t.data = 8'h11;
      sb.push_back(t);
      for (int k = 0; k < 3; k++) begin
         wait_grant(c);
         vectors++;
         if (c !== 1) begin
            miscompares++;
            $display("[TB] FAIL rr_latency[%0d]: %0d cycles, required 1", k, c);
         end
         step();
         if (k == 2) begin
            m1_req = 1'b0;
            m2_req = 1'b0;
         end
         finish_txn((k == 1) ? 2 : 1);
      end
   endtask

   task automatic test_hold_stable();
      int c;
      issue(2, INSTR_READ, 2'd2, 12'd1, 8'd5);
      wait_grant(c);
      m2_req = 1'b0;
      m2_instruction = INSTR_WRITE; m2_slave_select = 2'd3; m2_address = 12'hABC; m2_data = 8'h55;
      for (int k = 0; k < 3; k++) begin
         step();
         vectors++;
         if ({m2_grant, instruction, slave_select, address, data_out} !== {1'b1, INSTR_READ, 2'd2, 12'd1, 8'd5}) begin
            miscompares++;
            $display("[TB] FAIL hold_stable[%0d]: grant=%b bus=%b/%0d/%0h/%0d, required 1 and 11/2/1/5",
                     k, m2_grant, instruction, slave_select, address, data_out);
         end
      end
      finish_txn(2);
      vectors++;
      if ({slave_select, address, data_out} !== {2'd2, 12'd1, 8'd5}) begin
         miscompares++;
         $display("[TB] FAIL retain_fields: %0d/%0h/%0d, required 2/1/5", slave_select, address, data_out);
      end
   endtask

   task automatic test_idle_trans_done();
      trans_done = 1'b1;
      step();
      trans_done = 1'b0;
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if ({m1_grant, m2_grant, m1_done, m2_done, bus_busy} !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL idle_trans_done[%0d]: grant=%b done=%b busy=%b, required 0",
                     k, {m1_grant, m2_grant}, {m1_done, m2_done}, bus_busy);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_grant();
      int c;
      issue(2, INSTR_READ, 2'd3, 12'h0F0, 8'hA5);
      wait_grant(c);
      step();
      reset = 1'b1;
      m2_req = 1'b0;
      step();
      reset = 1'b0;
      vectors++;
      if ({m1_grant, m2_grant, m1_done, m2_done, instruction, slave_select, address, data_out, bus_busy}
          !== {4'b0000, INSTR_NONE, 2'd1, 12'd0, 8'd0, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL reset_mid_grant: grant=%b done=%b instr=%b sel=%0d addr=%0h data=%0d busy=%b, required reset values",
                  {m1_grant, m2_grant}, {m1_done, m2_done}, instruction, slave_select, address, data_out, bus_busy);
      end
      step();
      vectors++;
      if (m2_done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL no_done_after_reset: m2_done=%b, required 0", m2_done);
      end
      issue(1, INSTR_WRITE, 2'd0, 12'h100, 8'h01);
      issue(2, INSTR_WRITE, 2'd1, 12'h200, 8'h02);
      wait_grant(c);
      finish_txn(1);
      m1_req = 1'b0;
      wait_grant(c);
      m2_req = 1'b0;
      finish_txn(2);
   endtask

   task automatic test_instr_none();
      int c;
      issue(1, INSTR_NONE, 2'd3, 12'h3FF, 8'hFF);
      wait_grant(c);
      m1_req = 1'b0;
      for (int k = 0; k < 3; k++) step();
      vectors++;
      if ({m1_grant, bus_busy, instruction} !== {2'b11, INSTR_NONE}) begin
         miscompares++;
         $display("[TB] FAIL instr_none_hold: grant=%b busy=%b instr=%b, required 1/1/00", m1_grant, bus_busy, instruction);
      end
      finish_txn(1);
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      int c;
      do_reset();
      issue(1, INSTR_WRITE, 2'd2, 12'h055, 8'h33);
      wait_grant(c);
      m1_req = 1'b0;
      for (int k = 1; k < TIMEOUT_CYCLES; k++) begin
         step();
         vectors++;
         if ({m1_grant, timeout_err} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL timeout_early[%0d]: grant=%b err=%b, required 1/0", k, m1_grant, timeout_err);
         end
      end
      for (int k = 0; k < 4; k++) begin
         step();
         vectors++;
         if ({m1_grant, m1_done, timeout_err} !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL timeout_expired[%0d]: grant=%b done=%b err=%b, required 0/0/1", k, m1_grant, m1_done, timeout_err);
         end
      end
      do_reset();
      issue(2, INSTR_READ, 2'd1, 12'h066, 8'h44);
      wait_grant(c);
      m2_req = 1'b0;
      for (int k = 1; k < TIMEOUT_CYCLES; k++) step();
      finish_txn(2);
      vectors++;
      if (timeout_err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL done_at_limit: err=%b, required 0", timeout_err);
      end
   endtask
`else
   task automatic test_timeout();
      int c;
      issue(1, INSTR_WRITE, 2'd2, 12'h055, 8'h33);
      wait_grant(c);
      m1_req = 1'b0;
      for (int k = 0; k < 30; k++) step();
      vectors++;
      if ({m1_grant, timeout_err} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL grant_no_watchdog: grant=%b err=%b, required 1/0", m1_grant, timeout_err);
      end
      finish_txn(1);
   endtask
`endif

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_hold_stable();
      test_idle_trans_done();
      test_reset_mid_grant();
      test_instr_none();
      test_timeout();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: %0d pending, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute time bound so a stuck run still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL sim_timeout: run exceeded time bound");
      $fatal(1, "[TB] time bound exceeded");
   end

endmodule
